// File: rtl/wb_write_buffer_if.sv
// Write-back buffer bus: ALU and load result producers, register-file drain, forwarding lookup.
// The master modport belongs to the producer/consumer side; the slave modport belongs to the buffer.
`timescale 1ns/1ps
interface wb_write_buffer_if #(
    parameter int AW = 2
);
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [63:0] alu_data;
    logic        alu_ready;
    logic        ld_valid;
    logic [4:0]  ld_rd;
    logic [63:0] ld_data;
    logic        ld_ready;
    logic [31:0] wr_en;
    logic [63:0] wr_data;
    logic [4:0]  fwd_rd;
    logic        fwd_hit;
    logic [63:0] fwd_data;
    logic [AW:0] count;

    modport master (
        output alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data, fwd_rd,
        input  alu_ready, ld_ready, wr_en, wr_data, fwd_hit, fwd_data, count
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data, fwd_rd,
        output alu_ready, ld_ready, wr_en, wr_data, fwd_hit, fwd_data, count
    );
endinterface

// File: rtl/wb_write_buffer.sv
// In-order write-back queue draining one result per cycle into the register file, with youngest-match forwarding.
// Latency: one cycle after transfer (same cycle into an empty buffer when WB_BYPASS_EN is defined).
// Backpressure: ready from registered count only; load wins the last free slot.
`timescale 1ns/1ps
module wb_write_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic            clk,
    input  logic            reset_n,
    wb_write_buffer_if.slave bus
);
    localparam logic [4:0]  XZR     = 5'd31;
    localparam logic [AW:0] FULL    = (AW+1)'(DEPTH);
    localparam logic [AW:0] FULL_M1 = (AW+1)'(DEPTH - 1);

    logic [4:0]       rd_q   [DEPTH];
    logic [4:0]       rd_d   [DEPTH];
    logic [63:0]      data_q [DEPTH];
    logic [63:0]      data_d [DEPTH];
    logic [DEPTH-1:0] vld_q, vld_d;
    logic [AW-1:0]    head_q, head_d;
    logic [AW-1:0]    tail_q, tail_d;
    logic [AW:0]      count_q, count_d;

    logic          ld_xfer, alu_xfer;
    logic          ld_enq, alu_enq, deq;
    logic          byp_ld, byp_alu;
    logic [AW-1:0] alu_slot;
    logic [AW-1:0] fwd_idx;

    always_comb begin
        bus.ld_ready  = (count_q < FULL);
        bus.alu_ready = (count_q < FULL) && !(bus.ld_valid && (count_q == FULL_M1));
    end

    assign ld_xfer  = bus.ld_valid  && bus.ld_ready;
    assign alu_xfer = bus.alu_valid && bus.alu_ready;

`ifdef WB_BYPASS_EN
    // Only an empty buffer may bypass, so in-order retirement is preserved.
    assign byp_ld  = (count_q == '0) && ld_xfer && (bus.ld_rd != XZR);
    assign byp_alu = (count_q == '0) && alu_xfer && (bus.alu_rd != XZR) && !byp_ld;
`else
    assign byp_ld  = 1'b0;
    assign byp_alu = 1'b0;
`endif

    assign ld_enq   = ld_xfer  && (bus.ld_rd  != XZR) && !byp_ld;
    assign alu_enq  = alu_xfer && (bus.alu_rd != XZR) && !byp_alu;
    assign deq      = (count_q != '0);
    assign alu_slot = tail_q + AW'(ld_enq);

    always_comb begin
        rd_d    = rd_q;
        data_d  = data_q;
        vld_d   = vld_q;
        head_d  = head_q;
        tail_d  = tail_q + AW'(ld_enq) + AW'(alu_enq);
        count_d = count_q + (AW+1)'(ld_enq) + (AW+1)'(alu_enq) - (AW+1)'(deq);
        if (deq) begin
            vld_d[head_q] = 1'b0;
            head_d        = head_q + AW'(1);
        end
        if (ld_enq) begin
            rd_d[tail_q]   = bus.ld_rd;
            data_d[tail_q] = bus.ld_data;
            vld_d[tail_q]  = 1'b1;
        end
        if (alu_enq) begin
            rd_d[alu_slot]   = bus.alu_rd;
            data_d[alu_slot] = bus.alu_data;
            vld_d[alu_slot]  = 1'b1;
        end
    end

    always_comb begin
        bus.wr_en   = '0;
        bus.wr_data = '0;
        if (deq) begin
            bus.wr_en[rd_q[head_q]] = 1'b1;
            bus.wr_data             = data_q[head_q];
        end else if (byp_ld) begin
            bus.wr_en[bus.ld_rd] = 1'b1;
            bus.wr_data          = bus.ld_data;
        end else if (byp_alu) begin
            bus.wr_en[bus.alu_rd] = 1'b1;
            bus.wr_data           = bus.alu_data;
        end
    end

    // Walk oldest to youngest so the last match (youngest) overrides.
    always_comb begin
        bus.fwd_hit  = 1'b0;
        bus.fwd_data = '0;
        fwd_idx      = head_q;
        for (int i = 0; i < DEPTH; i++) begin
            fwd_idx = head_q + AW'(i);
            if (vld_q[fwd_idx] && (rd_q[fwd_idx] == bus.fwd_rd) && (bus.fwd_rd != XZR)) begin
                bus.fwd_hit  = 1'b1;
                bus.fwd_data = data_q[fwd_idx];
            end
        end
    end

    assign bus.count = count_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_q   <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                rd_q[i]   <= '0;
                data_q[i] <= '0;
            end
        end else begin
            vld_q   <= vld_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            rd_q    <= rd_d;
            data_q  <= data_d;
        end
    end

    assert property (@(posedge clk) disable iff (!reset_n) count_q <= FULL);
    assert property (@(posedge clk) disable iff (!reset_n) $onehot0(bus.wr_en));

endmodule

// File: tb/tb_wb_write_buffer.sv
// Directed bench for wb_write_buffer: inputs change 1ns after the rising edge, outputs are checked 1ns later.
`timescale 1ns/1ps
module tb_wb_write_buffer;
    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    wb_write_buffer_if #(.AW(2)) bus_if ();

    wb_write_buffer #(.DEPTH(4), .AW(2)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_if)
    );

    // Fill/wrap table: per cycle offers, then expected count, head rd (0 = empty) and alu_ready.
    int t_lv [11] = '{1, 1, 1, 0, 1, 0, 1, 0, 0, 0, 0};
    int t_lrd[11] = '{1, 3, 5, 0, 7, 0, 9, 0, 0, 0, 0};
    int t_av [11] = '{1, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0};
    int t_ard[11] = '{2, 4, 6, 6, 8, 8, 0, 0, 0, 0, 0};
    int t_cnt[11] = '{0, 2, 3, 3, 3, 3, 3, 3, 2, 1, 0};
    int t_hrd[11] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 0};
    int t_ar [11] = '{1, 1, 0, 1, 0, 1, 0, 1, 1, 1, 1};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic drive(input logic lv, input logic [4:0] lrd, input logic [63:0] ldat,
                         input logic av, input logic [4:0] ard, input logic [63:0] adat);
        bus_if.ld_valid  = lv;
        bus_if.ld_rd     = lrd;
        bus_if.ld_data   = ldat;
        bus_if.alu_valid = av;
        bus_if.alu_rd    = ard;
        bus_if.alu_data  = adat;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        logic [63:0] exp_en;
        logic [63:0] exp_dat;
        drive(1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0);
        bus_if.fwd_rd = 5'd0;
        repeat (2) @(posedge clk);
        #1;

        chk("rst_count",    64'(bus_if.count),     64'h0);
        chk("rst_wr_en",    64'(bus_if.wr_en),     64'h0);
        chk("rst_wr_data",  bus_if.wr_data,        64'h0);
        chk("rst_fwd_hit",  64'(bus_if.fwd_hit),   64'h0);
        chk("rst_fwd_data", bus_if.fwd_data,       64'h0);
        chk("rst_ld_rdy",   64'(bus_if.ld_ready),  64'h1);
        chk("rst_alu_rdy",  64'(bus_if.alu_ready), 64'h1);
        reset_n = 1'b1;
        next_cycle();

`ifndef WB_BYPASS_EN
        // Single ALU result x5
        drive(1'b0, 5'd0, 64'h0, 1'b1, 5'd5, 64'hDEAD_BEEF);
        settle();
        chk("x5_alu_rdy",   64'(bus_if.alu_ready), 64'h1);
        chk("x5_no_early",  64'(bus_if.wr_en),     64'h0);
        next_cycle();
        drive(1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0);
        bus_if.fwd_rd = 5'd5;
        settle();
        chk("x5_count",     64'(bus_if.count),     64'h1);
        chk("x5_wr_en",     64'(bus_if.wr_en),     64'h20);
        chk("x5_wr_data",   bus_if.wr_data,        64'hDEAD_BEEF);
        chk("x5_fwd_hit",   64'(bus_if.fwd_hit),   64'h1);
        chk("x5_fwd_data",  bus_if.fwd_data,       64'hDEAD_BEEF);
        next_cycle();
        settle();
        chk("x5_drained",   64'(bus_if.count),     64'h0);
        chk("x5_wr_en_off", 64'(bus_if.wr_en),     64'h0);
        chk("x5_fwd_miss",  64'(bus_if.fwd_hit),   64'h0);

        // Load and ALU to x3 in the same cycle: load is older
        drive(1'b1, 5'd3, 64'h11, 1'b1, 5'd3, 64'h22);
        settle();
        chk("dual_ld_rdy",  64'(bus_if.ld_ready),  64'h1);
        chk("dual_alu_rdy", 64'(bus_if.alu_ready), 64'h1);
        next_cycle();
        drive(1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0);
        bus_if.fwd_rd = 5'd3;
        settle();
        chk("dual_count2",  64'(bus_if.count),     64'h2);
        chk("dual_wr_en1",  64'(bus_if.wr_en),     64'h8);
        chk("dual_wr_dat1", bus_if.wr_data,        64'h11);
        chk("dual_fwd_hit", 64'(bus_if.fwd_hit),   64'h1);
        chk("dual_fwd_yng", bus_if.fwd_data,       64'h22);
        next_cycle();
        settle();
        chk("dual_count1",  64'(bus_if.count),     64'h1);
        chk("dual_wr_en2",  64'(bus_if.wr_en),     64'h8);
        chk("dual_wr_dat2", bus_if.wr_data,        64'h22);
        chk("dual_fwd_2",   bus_if.fwd_data,       64'h22);
        next_cycle();
        settle();
        chk("dual_count0",  64'(bus_if.count),     64'h0);
        chk("dual_fwd_off", bus_if.fwd_data,       64'h0);

        // Fill to the last free slot, arbitrate it, and wrap the pointers
        for (int c = 0; c < 11; c++) begin
            drive(1'(t_lv[c]), 5'(t_lrd[c]), 64'h100 + 64'(t_lrd[c]),
                  1'(t_av[c]), 5'(t_ard[c]), 64'h100 + 64'(t_ard[c]));
            settle();
            exp_en  = (t_hrd[c] == 0) ? 64'h0 : (64'h1 << t_hrd[c]);
            exp_dat = (t_hrd[c] == 0) ? 64'h0 : (64'h100 + 64'(t_hrd[c]));
            chk($sformatf("fill%0d_count", c),   64'(bus_if.count),     64'(t_cnt[c]));
            chk($sformatf("fill%0d_ld_rdy", c),  64'(bus_if.ld_ready),  64'h1);
            chk($sformatf("fill%0d_alu_rdy", c), 64'(bus_if.alu_ready), 64'(t_ar[c]));
            chk($sformatf("fill%0d_wr_en", c),   64'(bus_if.wr_en),     exp_en);
            chk($sformatf("fill%0d_wr_data", c), bus_if.wr_data,        exp_dat);
            if (c == 7) begin
                bus_if.fwd_rd = 5'd9;
                settle();
                chk("fill_fwd_hit",  64'(bus_if.fwd_hit), 64'h1);
                chk("fill_fwd_data", bus_if.fwd_data,     64'h109);
            end
            next_cycle();
        end

        // Writes to x31 complete the handshake but are discarded
        drive(1'b0, 5'd0, 64'h0, 1'b1, 5'd31, 64'hFF);
        settle();
        chk("xzr_alu_rdy",  64'(bus_if.alu_ready), 64'h1);
        next_cycle();
        drive(1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0);
        bus_if.fwd_rd = 5'd31;
        settle();
        chk("xzr_count",    64'(bus_if.count),     64'h0);
        chk("xzr_wr_en",    64'(bus_if.wr_en),     64'h0);
        chk("xzr_fwd_hit",  64'(bus_if.fwd_hit),   64'h0);
        chk("xzr_fwd_data", bus_if.fwd_data,       64'h0);
        drive(1'b1, 5'd31, 64'hAA, 1'b1, 5'd4, 64'h44);
        settle();
        next_cycle();
        drive(1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0);
        bus_if.fwd_rd = 5'd4;
        settle();
        chk("xzr_mix_count", 64'(bus_if.count),    64'h1);
        chk("xzr_mix_wr_en", 64'(bus_if.wr_en),    64'h10);
        chk("xzr_mix_data",  bus_if.wr_data,       64'h44);
        next_cycle();
        settle();
        chk("xzr_mix_done",  64'(bus_if.count),    64'h0);

        // Asynchronous reset with three entries pending
        drive(1'b1, 5'd10, 64'h10A, 1'b1, 5'd11, 64'h10B);
        next_cycle();
        drive(1'b1, 5'd12, 64'h10C, 1'b1, 5'd13, 64'h10D);
        next_cycle();
        drive(1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0);
        bus_if.fwd_rd = 5'd12;
        settle();
        chk("arst_pre_count", 64'(bus_if.count),   64'h3);
        chk("arst_pre_wr_en", 64'(bus_if.wr_en),   64'h800);
        #1 reset_n = 1'b0;
        #1;
        chk("arst_wr_en",    64'(bus_if.wr_en),    64'h0);
        chk("arst_count",    64'(bus_if.count),    64'h0);
        chk("arst_wr_data",  bus_if.wr_data,       64'h0);
        chk("arst_fwd_hit",  64'(bus_if.fwd_hit),  64'h0);
        chk("arst_fwd_data", bus_if.fwd_data,      64'h0);
        #1 reset_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            next_cycle();
            chk($sformatf("arst_post%0d_wr_en", k), 64'(bus_if.wr_en), 64'h0);
            chk($sformatf("arst_post%0d_count", k), 64'(bus_if.count), 64'h0);
        end
`else
        // Empty buffer: a single result is written in the same cycle
        drive(1'b0, 5'd0, 64'h0, 1'b1, 5'd7, 64'h42);
        settle();
        chk("byp_alu_rdy",  64'(bus_if.alu_ready), 64'h1);
        chk("byp_wr_en",    64'(bus_if.wr_en),     64'h80);
        chk("byp_wr_data",  bus_if.wr_data,        64'h42);
        chk("byp_count",    64'(bus_if.count),     64'h0);
        next_cycle();
        drive(1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0);
        settle();
        chk("byp_count_after", 64'(bus_if.count),  64'h0);
        chk("byp_wr_en_after", 64'(bus_if.wr_en),  64'h0);
        // Both sources into an empty buffer: load bypasses, ALU queues
        drive(1'b1, 5'd3, 64'h11, 1'b1, 5'd3, 64'h22);
        settle();
        chk("byp_dual_wr_en", 64'(bus_if.wr_en),   64'h8);
        chk("byp_dual_data1", bus_if.wr_data,      64'h11);
        next_cycle();
        drive(1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0);
        bus_if.fwd_rd = 5'd3;
        settle();
        chk("byp_dual_count", 64'(bus_if.count),   64'h1);
        chk("byp_dual_data2", bus_if.wr_data,      64'h22);
        chk("byp_dual_fwd",   bus_if.fwd_data,     64'h22);
        next_cycle();
        settle();
        chk("byp_dual_done",  64'(bus_if.count),   64'h0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
